// File: rtl/rgb_pixel_feeder.sv
// rgb_pixel_feeder: buffers RGB pixels in a small FIFO and walks each one through the
// converter's level-based enable/ready handshake. The HSV result is held in a
// one-entry output slot. A watchdog bounds the time spent waiting on the converter.
module rgb_pixel_feeder #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        pixel_valid,
  output logic                        pixel_ready,
  input  logic [23:0]                 pixel_rgb,
  output logic                        convert_enable,
  output logic [7:0]                  red_channel,
  output logic [7:0]                  green_channel,
  output logic [7:0]                  blue_channel,
  input  logic                        conversion_ready,
  input  logic [8:0]                  hue_in,
  input  logic [7:0]                  saturation_in,
  input  logic [7:0]                  value_in,
  output logic                        hsv_valid,
  input  logic                        hsv_ready,
  output logic [24:0]                 hsv_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        timeout_error,
  input  logic                        error_clear
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LvlFull = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRequest, StRelease} state_e;

  logic [23:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [LW-1:0] r_level;
  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [23:0]   r_rgb;
  logic          r_hsv_valid;
  logic [24:0]   r_hsv_data;
  logic          r_timeout_error;

  logic w_push, w_pop, w_empty, w_full;
  logic w_capture, w_expire, w_cnt_clr, w_cnt_inc;

  assign w_empty        = (r_level == '0);
  assign w_full         = (r_level == LvlFull);
  assign w_push         = pixel_valid && !w_full;
  assign pixel_ready    = !w_full;
  assign fifo_level     = r_level;
  assign convert_enable = (r_state == StRequest);
  assign red_channel    = r_rgb[23:16];
  assign green_channel  = r_rgb[15:8];
  assign blue_channel   = r_rgb[7:0];
  assign hsv_valid      = r_hsv_valid;
  assign hsv_data       = r_hsv_data;
  assign timeout_error  = r_timeout_error;

  // Pixel storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= pixel_rgb;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Next-state and control decode for the handshake sequencer.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_capture    = 1'b0;
    w_expire     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    unique case (r_state)
      StIdle: begin
        // A full output slot stalls the next pop so no result is ever overwritten.
        if (!w_empty && !r_hsv_valid) begin
          w_pop        = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = StRequest;
        end
      end
      StRequest: begin
        if (conversion_ready) begin
          w_capture    = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = StRelease;
        end else if (r_cnt == CntMax) begin
          w_expire     = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = StRelease;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      StRelease: begin
        if (!conversion_ready) begin
          w_cnt_clr    = 1'b1;
          w_state_next = StIdle;
        end else if (r_cnt == CntMax) begin
          w_expire     = 1'b1;
          w_cnt_clr    = 1'b1;
          w_state_next = StIdle;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Sequencer state, watchdog counter and the channel registers loaded on pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_cnt_clr)      r_cnt <= '0;
      else if (w_cnt_inc) r_cnt <= r_cnt + CW'(1);
      if (w_pop) r_rgb <= r_mem[r_rd_ptr];
    end
  end

  // Output slot and sticky watchdog flag; a new timeout beats a simultaneous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hsv_valid     <= 1'b0;
      r_hsv_data      <= '0;
      r_timeout_error <= 1'b0;
    end else begin
      if (w_capture) begin
        r_hsv_valid <= 1'b1;
        r_hsv_data  <= {hue_in, saturation_in, value_in};
      end else if (r_hsv_valid && hsv_ready) begin
        r_hsv_valid <= 1'b0;
      end
      if (w_expire)         r_timeout_error <= 1'b1;
      else if (error_clear) r_timeout_error <= 1'b0;
    end
  end

endmodule
